// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into internal storage,
// with an indexed 128-bit round-key read port for the round datapath.
module aes_key_expander #(
    parameter int MAX_NK     = 8,
    parameter int RK_REG_OUT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  keys_valid,
    output logic [3:0]            nr_out,
    input  logic [3:0]            rk_idx,
    output logic [127:0]          rk_out
);

    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = $clog2(MAX_NK);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FINISH} state_t;

    state_t            state, next_state;
    logic [32*MAX_NK-1:0] key_r;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       win [MAX_NK];
    logic [2:0]        nk_m1;
    logic [2:0]        imod;
    logic [AW-1:0]     i_cnt;
    logic [AW-1:0]     last_idx;
    logic [7:0]        rcon;
    logic [3:0]        nk_in;
    logic              legal, accept, reject;
    logic [31:0]       prev, temp, w_new;
    logic [5:0]        last_calc;
    logic              in_range;
    logic [AW-1:0]     rd_base;
    logic [127:0]      rk_next;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] key_word(input logic [32*MAX_NK-1:0] k, input int n);
        return k[32*(MAX_NK-n)-1 -: 32];
    endfunction

    // A start that lands in the done cycle is dropped even though the FSM is already back in IDLE.
    assign nk_in     = {1'b0, key_len, 1'b0} + 4'd4;
    assign legal     = (key_len != 2'd3) && (nk_in <= 4'(MAX_NK));
    assign accept    = (state == IDLE) && !done && start && legal;
    assign reject    = (state == IDLE) && !done && start && !legal;
    assign last_calc = {nk_in + 4'd7, 2'b00} - 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LOAD;
            LOAD:    next_state = EXPAND;
            EXPAND:  if (i_cnt == last_idx) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            keys_valid <= 1'b0;
            nr_out     <= 4'd0;
        end else begin
            done <= 1'b0;
            err  <= reject;
            if (accept) begin
                busy       <= 1'b1;
                keys_valid <= 1'b0;
                nr_out     <= nk_in + 4'd6;
            end
            if (state == FINISH) begin
                done       <= 1'b1;
                busy       <= 1'b0;
                keys_valid <= 1'b1;
            end
        end
    end

    // Window slot 0 always holds w[i-Nk] and slot Nk-1 holds w[i-1].
    always_comb begin
        prev = win[WW'(nk_m1)];
        temp = prev;
        if (imod == 3'd0)
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
        else if (nk_m1 == 3'd7 && imod == 3'd4)
            temp = sub_word(prev);
        w_new = win[0] ^ temp;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            key_r    <= key_in;
            nk_m1    <= 3'(nk_in - 4'd1);
            last_idx <= AW'(last_calc);
        end
        if (state == LOAD) begin
            for (int k = 0; k < MAX_NK; k++) begin
                win[WW'(k)] <= key_word(key_r, k);
                if (k <= int'(nk_m1))
                    mem[AW'(k)] <= key_word(key_r, k);
            end
            i_cnt <= AW'(nk_m1) + AW'(1);
            imod  <= 3'd0;
            rcon  <= 8'h01;
        end
        if (state == EXPAND) begin
            mem[i_cnt] <= w_new;
            for (int k = 0; k < MAX_NK - 1; k++)
                win[WW'(k)] <= win[WW'(k + 1)];
            win[WW'(nk_m1)] <= w_new;
            i_cnt <= i_cnt + AW'(1);
            imod  <= (imod == nk_m1) ? 3'd0 : imod + 3'd1;
            if (imod == 3'd0)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

    assign in_range = keys_valid && (rk_idx <= nr_out);
    assign rd_base  = in_range ? AW'({rk_idx, 2'b00}) : '0;
    assign rk_next  = in_range ? {mem[rd_base], mem[rd_base + AW'(1)],
                                  mem[rd_base + AW'(2)], mem[rd_base + AW'(3)]} : 128'h0;

    generate
        if (RK_REG_OUT != 0) begin : g_rk_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rk_out <= 128'h0;
                else        rk_out <= rk_next;
            end
        end else begin : g_rk_comb
            assign rk_out = rk_next;
        end
    endgenerate

endmodule
